regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port (DA / data_in / WR) of the 8x8 register file between two writeback requesters, e.g. ALU writeback and load writeback.
- Each requester gets a valid/ready handshake and a one-entry holding buffer.
- Round-robin arbitration, with age ordering for same-address conflicts; writes to R0 are discarded.
- Exports a pending-write mask so hazard logic can stall reads of registers with writes in flight.

Parameters:
DATA_W, 8, data width of a register
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has a write
req0_addr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 may transfer this cycle
req1_valid  in  1  requester 1 has a write
req1_addr  in  ADDR_W  requester 1 destination register
req1_data  in  DATA_W  requester 1 write data
req1_ready  out  1  requester 1 may transfer this cycle
DA  out  ADDR_W  register-file write address (registered)
data_in  out  DATA_W  register-file write data (registered)
WR  out  1  register-file write enable (registered)
grant_id  out  1  requester whose write is on DA/data_in/WR (registered)
pending_mask  out  2**ADDR_W  bit k set while a write to Rk is buffered or on the port

Behaviour:
- Reset (asynchronous, any time): both buffers empty, older flag cleared, rr_ptr=0 (req0 favoured), WR=0, DA=0, data_in=0, grant_id=0. Buffered writes are discarded, including mid-transfer.
- Buffer i state: buf_valid, buf_addr, buf_data.
- Readiness: reqi_ready = ~buf_valid_i | gnt_i, where gnt_i is this cycle's grant to buffer i. Ready is combinational from state only; it never depends on reqi_valid.
- Transfer on reqi_valid & reqi_ready at the rising edge; the buffer loads and the entry is visible to the arbiter the next cycle.
- Address 0: a transfer with reqi_addr==0 is accepted, but the buffer stays empty. No WR is ever issued and pending_mask is unaffected.
- Arbitration (combinational over buffer state, at most one grant per cycle):
  - Only one buffer valid: grant it.
  - Both valid, buf_addr equal: grant the older entry.
  - Both valid, addresses differ: grant buffer rr_ptr.
  - After any grant, rr_ptr = ~(granted index).
- Age tracking:
  - A buffer loading while the other already holds a valid entry is younger.
  - Both loading on the same edge: buffer 0 is older.
  - The older flag clears when either entry drains.
- Issue: at the edge of a grant, WR<=1, DA<=buf_addr, data_in<=buf_data, grant_id<=index. The buffer empties unless refilled on the same edge. With no grant, WR<=0 and DA/data_in/grant_id hold their values.
- Latency: transfer at edge N → WR high after edge N+1; the register file commits at edge N+2.
- Throughput: one write per cycle aggregate. A single streaming requester also sustains one per cycle.
- pending_mask[k] = (buf_valid0 & buf_addr0==k) | (buf_valid1 & buf_addr1==k) | (WR & DA==k). Bit 0 is always 0.
- Simultaneous refill and grant of the same buffer: the new entry is younger than any entry in the other buffer.
- Write order to any single register matches acceptance order. Same-edge ties go req0 first, then req1.

Test Plan:
- Reset: drive traffic, assert rst mid-cycle → WR=0, DA=0, data_in=0, pending_mask=0 immediately; both readies=1 after release.
- Single write: req0 addr=1 data=0x05 transfers at edge N → pending_mask=0x02 after N; WR=1, DA=1, data_in=0x05, grant_id=0 after N+1; R1 reads 5; mask returns to 0 after N+2.
- Fairness: both valid continuously, req0 addr=2, req1 addr=4 → grants alternate 0,1,0,1 with WR held high. Each requester sees ready every other cycle, so aggregate throughput is one write per cycle.
- R0 discard: req1 addr=0 data=0xFF → accepted (ready=1); WR stays 0 for 4 cycles; pending_mask=0; R0 reads 0.
- Same-address conflict: req0 addr=3 data=0x55 and req1 addr=3 data=0xAA on the same edge → 0x55 issued first, then 0xAA; R3 reads 0xAA.
- Reset with pending: both buffers full, rst pulse → no WR afterwards; registers keep their pre-reset contents or reset values per the register file; pending_mask=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for the 8-entry register file: one-entry buffer per requester, round-robin/age grant.
// Latency: accept at edge N, WR at N+1. Ready = buffer empty or draining this cycle; one write per cycle aggregate.
module regfile_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [ADDR_W-1:0]    req0_addr,
   input  logic [DATA_W-1:0]    req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [ADDR_W-1:0]    req1_addr,
   input  logic [DATA_W-1:0]    req1_data,
   output logic                 req1_ready,
   output logic [ADDR_W-1:0]    DA,
   output logic [DATA_W-1:0]    data_in,
   output logic                 WR,
   output logic                 grant_id,
   output logic [2**ADDR_W-1:0] pending_mask
);

   localparam int NREG = 2**ADDR_W;

   logic [1:0]        buf_valid;
   logic [ADDR_W-1:0] buf_addr [2];
   logic [DATA_W-1:0] buf_data [2];
   logic              age_vld;
   logic              age_idx;
   logic              rr_ptr;

   logic [1:0]        req_valid;
   logic [ADDR_W-1:0] req_addr [2];
   logic [DATA_W-1:0] req_data [2];
   logic [1:0]        gnt;
   logic              gnt_idx;
   logic [1:0]        ready;
   logic [1:0]        load;
   logic [1:0]        stay;
   logic              age_vld_nxt;
   logic              age_idx_nxt;

   always_comb begin
      req_valid   = {req1_valid, req0_valid};
      req_addr[0] = req0_addr;
      req_addr[1] = req1_addr;
      req_data[0] = req0_data;
      req_data[1] = req1_data;
   end

   // Same-address entries must drain oldest first; otherwise alternate.
   always_comb begin
      gnt = 2'b00;
      case (buf_valid)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            if (buf_addr[0] == buf_addr[1])
               gnt = (age_vld && age_idx) ? 2'b10 : 2'b01;
            else
               gnt = rr_ptr ? 2'b10 : 2'b01;
         end
         default: gnt = 2'b00;
      endcase
      gnt_idx = gnt[1];
   end

   always_comb begin
      ready = ~buf_valid | gnt;
      stay  = buf_valid & ~gnt;
      for (int i = 0; i < 2; i++)
         load[i] = req_valid[i] & ready[i] & (req_addr[i] != '0);
   end

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   // A freshly loaded entry is younger than whatever the other buffer keeps holding.
   always_comb begin
      age_vld_nxt = age_vld;
      age_idx_nxt = age_idx;
      if (load == 2'b11) begin
         age_vld_nxt = 1'b1;
         age_idx_nxt = 1'b0;
      end else if (load[0]) begin
         age_vld_nxt = stay[1];
         age_idx_nxt = 1'b1;
      end else if (load[1]) begin
         age_vld_nxt = stay[0];
         age_idx_nxt = 1'b0;
      end else if (|gnt) begin
         age_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            buf_addr[i] <= '0;
            buf_data[i] <= '0;
         end
         age_vld <= 1'b0;
         age_idx <= 1'b0;
         rr_ptr  <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            buf_valid[i] <= load[i] | stay[i];
            if (load[i]) begin
               buf_addr[i] <= req_addr[i];
               buf_data[i] <= req_data[i];
            end
         end
         age_vld <= age_vld_nxt;
         age_idx <= age_idx_nxt;
         if (|gnt)
            rr_ptr <= ~gnt_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WR       <= 1'b0;
         DA       <= '0;
         data_in  <= '0;
         grant_id <= 1'b0;
      end else if (|gnt) begin
         WR       <= 1'b1;
         DA       <= buf_addr[gnt_idx];
         data_in  <= buf_data[gnt_idx];
         grant_id <= gnt_idx;
      end else begin
         WR <= 1'b0;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int k = 1; k < NREG; k++)
         pending_mask[k] = (buf_valid[0] && buf_addr[0] == ADDR_W'(k)) ||
                           (buf_valid[1] && buf_addr[1] == ADDR_W'(k)) ||
                           (WR && DA == ADDR_W'(k));
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: per-cycle vector table, per-register ordering scoreboard, reset sequences.
module tb_regfile_wr_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_addr, req1_addr;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [2:0] DA;
   logic [7:0] data_in;
   logic       WR;
   logic       grant_id;
   logic [7:0] pending_mask;

   regfile_wr_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .DA(DA), .data_in(data_in), .WR(WR), .grant_id(grant_id), .pending_mask(pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       v0;
      logic [2:0] a0;
      logic [7:0] d0;
      logic       v1;
      logic [2:0] a1;
      logic [7:0] d1;
      logic       r0;
      logic       r1;
      logic       wr;
      logic [2:0] da;
      logic [7:0] din;
      logic       gid;
      logic [7:0] mask;
   } vec_t;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   localparam int NV = 35;
   vec_t vecs [NV];
   wr_t  sb_q [$];
   logic [7:0] rf [8];
   int tests;
   int fails;

   function automatic vec_t mk(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                               input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                               input logic r0, input logic r1, input logic wr, input logic [2:0] da,
                               input logic [7:0] din, input logic gid, input logic [7:0] mask);
      vec_t v;
      v = {v0, a0, d0, v1, a1, d1, r0, r1, wr, da, din, gid, mask};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [7:0] d1);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      #1;
      // Acceptance order is the required commit order per register; req0 first on a tie.
      if (req0_valid && req0_ready && req0_addr != 3'd0) sb_q.push_back({req0_addr, req0_data});
      if (req1_valid && req1_ready && req1_addr != 3'd0) sb_q.push_back({req1_addr, req1_data});
   endtask

   // Register-file model plus write monitor: every WR must match the oldest outstanding write to DA.
   always @(negedge clk) begin
      int idx;
      if (!rst && WR) begin
         idx = -1;
         foreach (sb_q[j])
            if (idx < 0 && sb_q[j].a == DA) idx = j;
         tests++;
         if (DA == 3'd0 || idx < 0) begin
            fails++;
            $display("FAIL sb_unexpected_write: got DA=%0d data=%h expected no write", DA, data_in);
         end else begin
            if (data_in !== sb_q[idx].d) begin
               fails++;
               $display("FAIL sb_data R%0d: got %h expected %h", DA, data_in, sb_q[idx].d);
            end
            sb_q.delete(idx);
         end
         rf[DA] <= data_in;
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      foreach (rf[k]) rf[k] = 8'h00;
      rst = 1'b1;
      req0_valid = 0; req0_addr = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0;

      vecs[0]  = mk(1,1,'h05, 0,0,0,      1,1, 0,0,'h00,0,'h00);
      vecs[1]  = mk(0,0,0,    0,0,0,      1,1, 0,0,'h00,0,'h02);
      vecs[2]  = mk(0,0,0,    0,0,0,      1,1, 1,1,'h05,0,'h02);
      vecs[3]  = mk(0,0,0,    0,0,0,      1,1, 0,1,'h05,0,'h00);
      vecs[4]  = mk(1,2,'h22, 1,4,'h44,   1,1, 0,1,'h05,0,'h00);
      vecs[5]  = mk(1,2,'h22, 1,4,'h44,   0,1, 0,1,'h05,0,'h14);
      vecs[6]  = mk(1,2,'h22, 1,4,'h44,   1,0, 1,4,'h44,1,'h14);
      vecs[7]  = mk(1,2,'h22, 1,4,'h44,   0,1, 1,2,'h22,0,'h14);
      vecs[8]  = mk(1,2,'h22, 1,4,'h44,   1,0, 1,4,'h44,1,'h14);
      vecs[9]  = mk(0,0,0,    0,0,0,      0,1, 1,2,'h22,0,'h14);
      vecs[10] = mk(0,0,0,    0,0,0,      1,1, 1,4,'h44,1,'h14);
      vecs[11] = mk(0,0,0,    0,0,0,      1,1, 1,2,'h22,0,'h04);
      vecs[12] = mk(0,0,0,    0,0,0,      1,1, 0,2,'h22,0,'h00);
      vecs[13] = mk(0,0,0,    1,0,'hFF,   1,1, 0,2,'h22,0,'h00);
      for (int i = 14; i < 18; i++)
         vecs[i] = mk(0,0,0,  0,0,0,      1,1, 0,2,'h22,0,'h00);
      vecs[18] = mk(1,3,'h55, 1,3,'hAA,   1,1, 0,2,'h22,0,'h00);
      vecs[19] = mk(0,0,0,    0,0,0,      1,0, 0,2,'h22,0,'h08);
      vecs[20] = mk(0,0,0,    0,0,0,      1,1, 1,3,'h55,0,'h08);
      vecs[21] = mk(0,0,0,    0,0,0,      1,1, 1,3,'hAA,1,'h08);
      vecs[22] = mk(0,0,0,    0,0,0,      1,1, 0,3,'hAA,1,'h00);
      vecs[23] = mk(1,6,'h61, 1,5,'h51,   1,1, 0,3,'hAA,1,'h00);
      vecs[24] = mk(1,5,'h52, 0,0,0,      1,0, 0,3,'hAA,1,'h60);
      vecs[25] = mk(0,0,0,    0,0,0,      0,1, 1,6,'h61,0,'h60);
      vecs[26] = mk(0,0,0,    0,0,0,      1,1, 1,5,'h51,1,'h20);
      vecs[27] = mk(0,0,0,    0,0,0,      1,1, 1,5,'h52,0,'h20);
      vecs[28] = mk(0,0,0,    0,0,0,      1,1, 0,5,'h52,0,'h00);
      vecs[29] = mk(1,7,'h71, 0,0,0,      1,1, 0,5,'h52,0,'h00);
      vecs[30] = mk(1,7,'h72, 0,0,0,      1,1, 0,5,'h52,0,'h80);
      vecs[31] = mk(1,7,'h73, 0,0,0,      1,1, 1,7,'h71,0,'h80);
      vecs[32] = mk(0,0,0,    0,0,0,      1,1, 1,7,'h72,0,'h80);
      vecs[33] = mk(0,0,0,    0,0,0,      1,1, 1,7,'h73,0,'h80);
      vecs[34] = mk(0,0,0,    0,0,0,      1,1, 0,7,'h73,0,'h00);

      repeat (2) @(negedge clk);
      check("reset_state", {req0_ready, req1_ready, WR, DA, data_in, grant_id, pending_mask},
            {1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00});
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         check($sformatf("row%0d", i), {req0_ready, req1_ready, WR, DA, data_in, grant_id, pending_mask},
               {vecs[i].r0, vecs[i].r1, vecs[i].wr, vecs[i].da, vecs[i].din, vecs[i].gid, vecs[i].mask});
         drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      end

      @(negedge clk);
      #1;
      check("rf_R0", rf[0], 8'h00);
      check("rf_R1", rf[1], 8'h05);
      check("rf_R2", rf[2], 8'h22);
      check("rf_R3", rf[3], 8'hAA);
      check("rf_R4", rf[4], 8'h44);
      check("rf_R5", rf[5], 8'h52);
      check("rf_R6", rf[6], 8'h61);
      check("rf_R7", rf[7], 8'h73);
      check("sb_drained", sb_q.size(), 0);

      // Reset mid-cycle with one write on the port and one still buffered.
      @(negedge clk);
      drive(1, 1, 8'h11, 1, 2, 8'h12);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      check("pre_reset_wr", {WR, DA, data_in, grant_id}, {1'b1, 3'd2, 8'h12, 1'b1});
      #2 rst = 1'b1;
      #1;
      check("async_reset_out", {WR, DA, data_in, grant_id, pending_mask}, {1'b1 ^ 1'b1, 3'd0, 8'h00, 1'b0, 8'h00});
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_reset", {req0_ready, req1_ready}, 2'b11);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post_reset_idle%0d", c), {WR, pending_mask}, 9'h000);
      end
      check("rf_R1_kept", rf[1], 8'h05);
      check("rf_R2_issued", rf[2], 8'h12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
